// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe
//   Two-stage normalise / round / pack stage of the FP adder, with valid/ready
//   flow control. Stage 1 normalises the aligned sum, and stage 2 rounds it and
//   packs the result.
//   The build macro FP_DENORM_EN selects the underflow behaviour. When it is
//   defined, results underflow gradually to subnormals. When it is undefined,
//   tiny results flush to a signed zero.
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready does not depend on in_valid)
//   in_sign, in_exp       sign and pre-normalisation exponent
//   in_carry, in_mant     adder carry-out and aligned mantissa (hidden bit at [MAN_W])
//   in_grs                guard / round / sticky
//   in_class              00 finite, 01 zero, 10 inf, 11 NaN
//   in_rm                 00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   out_valid / out_ready output handshake
//   out_result            {sign, exp, mant}
//   out_flags             {invalid, overflow, underflow, inexact}
module fp_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic                   in_carry,
    input  logic [MAN_W:0]         in_mant,
    input  logic [2:0]             in_grs,
    input  logic [1:0]             in_class,
    input  logic [1:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [3:0]             out_flags
);
    localparam int EW = EXP_W + 2;
    localparam int RW = 1 + EXP_W + MAN_W;
    localparam logic [1:0] CLS_FIN  = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] RM_RNE   = 2'b00;
    localparam logic [1:0] RM_RTZ   = 2'b01;
    localparam logic [1:0] RM_RUP   = 2'b10;
    localparam logic [EW-1:0] EXP_OVF = EW'((1 << EXP_W) - 1);

    logic adv1, adv2;
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic s1_sign_q, s1_sign_d;
    logic [EW-1:0] s1_exp_q, s1_exp_d;
    logic [MAN_W:0] s1_mant_q, s1_mant_d;
    logic [2:0] s1_grs_q, s1_grs_d;
    logic [1:0] s1_class_q, s1_class_d, s1_rm_q, s1_rm_d;
    logic [RW-1:0] res_q, res_d, res_n;
    logic [3:0] flags_q, flags_d, flags_n;

    // Stage 1: normalise
    logic [EW-1:0] exp_ext, lzc, max_sh, sh;
    logic [MAN_W+3:0] wide;

    always_comb begin
        adv2 = !s2_valid_q || out_ready;
        adv1 = !s1_valid_q || adv2;
        exp_ext = {2'b00, in_exp};
        lzc = EW'(MAN_W + 1);
        for (int i = 0; i <= MAN_W; i++) begin
            if (in_mant[i]) lzc = EW'(MAN_W - i);
        end
        // Left shift stops at exp 1, where the value becomes subnormal.
        max_sh = (exp_ext == '0) ? '0 : exp_ext - EW'(1);
        sh = (lzc < max_sh) ? lzc : max_sh;
        wide = {in_mant, in_grs} << sh;

        s1_valid_d = adv1 ? in_valid : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        s1_grs_d   = s1_grs_q;
        s1_class_d = s1_class_q;
        s1_rm_d    = s1_rm_q;
        if (adv1 && in_valid) begin
            s1_sign_d  = in_sign;
            s1_class_d = in_class;
            s1_rm_d    = in_rm;
            s1_exp_d   = exp_ext;
            s1_mant_d  = in_mant;
            s1_grs_d   = in_grs;
            if (in_class == CLS_FIN) begin
                if (in_carry) begin
                    s1_mant_d = {in_carry, in_mant[MAN_W:1]};
                    s1_grs_d  = {in_mant[0], in_grs[2], |in_grs[1:0]};
                    s1_exp_d  = exp_ext + EW'(1);
                end else if (in_mant == '0) begin
                    // Exact cancellation is carried as a zero-class beat.
                    s1_class_d = CLS_ZERO;
                    s1_exp_d   = '0;
                    s1_mant_d  = '0;
                    s1_grs_d   = '0;
                    if (in_rm == 2'b11) s1_sign_d = 1'b1;
                end else begin
                    s1_mant_d = wide[MAN_W+3:3];
                    s1_grs_d  = wide[2:0];
                    // Subnormal inputs (exp 0) carry an effective exponent of 1.
                    s1_exp_d  = (exp_ext == '0) ? EW'(1) : exp_ext - sh;
                end
            end
        end
    end

    // Stage 2: round and pack
    logic inc, inexact, tiny, hidden, to_inf;
    logic [MAN_W+1:0] sum;
    logic [MAN_W:0] mant_r;
    logic [EW-1:0] exp_r;

    always_comb begin
        inexact = |s1_grs_q;
        tiny    = !s1_mant_q[MAN_W];
        case (s1_rm_q)
            RM_RNE:  inc = s1_grs_q[2] && (s1_grs_q[1] || s1_grs_q[0] || s1_mant_q[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = !s1_sign_q && inexact;
            default: inc = s1_sign_q && inexact;
        endcase
        sum = {1'b0, s1_mant_q} + (MAN_W+2)'(inc);
        if (sum[MAN_W+1]) begin
            mant_r = {1'b1, {MAN_W{1'b0}}};
            exp_r  = s1_exp_q + EW'(1);
        end else begin
            mant_r = sum[MAN_W:0];
            exp_r  = s1_exp_q;
        end
        hidden = mant_r[MAN_W];
        to_inf = (s1_rm_q == RM_RNE) || (s1_rm_q == RM_RUP && !s1_sign_q) ||
                 (s1_rm_q == 2'b11 && s1_sign_q);

        res_n   = {s1_sign_q, (hidden ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), mant_r[MAN_W-1:0]};
        flags_n = {2'b00, tiny && inexact, inexact};
        if (hidden && exp_r >= EXP_OVF) begin
            res_n   = to_inf ? {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            flags_n = 4'b0101;
        end
`ifndef FP_DENORM_EN
        else if (!hidden) begin
            res_n   = {s1_sign_q, {(RW-1){1'b0}}};
            flags_n = 4'b0011;
        end
`endif
        if (s1_class_q == CLS_ZERO) begin
            res_n   = {s1_sign_q, {(RW-1){1'b0}}};
            flags_n = 4'b0000;
        end else if (s1_class_q == CLS_INF) begin
            res_n   = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_n = 4'b0000;
        end else if (s1_class_q != CLS_FIN) begin
            res_n   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_n = 4'b1000;
        end

        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        res_d      = res_q;
        flags_d    = flags_q;
        if (adv2 && s1_valid_q) begin
            res_d   = res_n;
            flags_d = flags_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_grs_q   <= '0;
            s1_class_q <= '0;
            s1_rm_q    <= '0;
            res_q      <= '0;
            flags_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s1_grs_q   <= s1_grs_d;
            s1_class_q <= s1_class_d;
            s1_rm_q    <= s1_rm_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
        end
    end

    assign in_ready   = adv1;
    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_flags  = flags_q;
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb_fp_norm_round_pipe
//   Scoreboard bench for fp_norm_round_pipe with EXP_W=8 and MAN_W=23.
//   Expected results are queued when a beat is accepted. They are compared in
//   order when the DUT presents a result and out_ready is high.
module tb_fp_norm_round_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, in_sign, in_carry, out_valid, out_ready;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic [2:0]  in_grs;
    logic [1:0]  in_class, in_rm;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    always #5 clock = ~clock;

    fp_norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_carry(in_carry),
        .in_mant(in_mant), .in_grs(in_grs), .in_class(in_class), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    typedef struct {
        logic        sign;
        logic [7:0]  ex;
        logic        carry;
        logic [23:0] mant;
        logic [2:0]  grs;
        logic [1:0]  cls;
        logic [1:0]  rm;
        logic [31:0] res;
        logic [3:0]  flags;
    } beat_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic rand_bp = 1'b0;
    logic [35:0] sb_q[$];
    beat_t vec[$];
    beat_t bpv[3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic beat_t mk(input logic s, input logic [7:0] e, input logic c,
                                 input logic [23:0] m, input logic [2:0] g,
                                 input logic [1:0] cl, input logic [1:0] rm,
                                 input logic [31:0] r, input logic [3:0] f);
        beat_t b;
        b.sign = s; b.ex = e; b.carry = c; b.mant = m; b.grs = g;
        b.cls = cl; b.rm = rm; b.res = r; b.flags = f;
        return b;
    endfunction

    // Normal finite operand needing no shift: only rounding can change it.
    function automatic beat_t mk_rand();
        beat_t b;
        logic up;
        logic [24:0] m;
        logic [7:0] e;
        b.sign  = 1'($urandom_range(0, 1));
        b.ex    = 8'($urandom_range(16, 224));
        b.carry = 1'b0;
        b.mant  = {1'b1, 23'($urandom)};
        b.grs   = 3'($urandom_range(0, 7));
        b.cls   = 2'b00;
        b.rm    = 2'($urandom_range(0, 3));
        case (b.rm)
            2'd0:    up = (b.grs > 3'b100) || (b.grs == 3'b100 && b.mant[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = (b.grs != 0) && !b.sign;
            default: up = (b.grs != 0) && b.sign;
        endcase
        m = {1'b0, b.mant} + {24'd0, up};
        e = b.ex;
        if (m[24]) e = e + 8'd1;
        b.res   = {b.sign, e, m[22:0]};
        b.flags = {3'b000, b.grs != 0};
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_sign = b.sign; in_exp = b.ex; in_carry = b.carry; in_mant = b.mant;
        in_grs = b.grs; in_class = b.cls; in_rm = b.rm;
    endtask

    task automatic send(input beat_t b);
        int waited = 0;
        drive(b);
        in_valid = 1'b1;
        #4;
        while (!in_ready && waited < 200) begin
            @(negedge clock);
            #4;
            waited++;
        end
        if (in_ready) sb_q.push_back({b.res, b.flags});
        else chk("send_timeout", 64'd0, 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 500) begin
            @(negedge clock);
            w++;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : monitor
        logic [35:0] e;
        forever begin
            @(negedge clock);
            #4;
            if (!reset && out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_out", 64'(out_result), 64'hDEAD_0000_0000);
                else begin
                    e = sb_q.pop_front();
                    chk($sformatf("result#%0d", n_out), 64'(out_result), 64'(e[35:4]));
                    chk($sformatf("flags#%0d", n_out), 64'(out_flags), 64'(e[3:0]));
                    n_out++;
                end
            end
        end
    end

    initial begin : bp_toggle
        forever begin
            @(negedge clock);
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int acc, idx;
        vec.push_back(mk(0, 8'h7F, 0, 24'h800000, 3'b100, 0, 0, 32'h3F800000, 4'b0001));
        vec.push_back(mk(0, 8'h7F, 0, 24'h800001, 3'b100, 0, 0, 32'h3F800002, 4'b0001));
        vec.push_back(mk(0, 8'h7F, 0, 24'h800001, 3'b100, 0, 1, 32'h3F800001, 4'b0001));
        vec.push_back(mk(0, 8'h80, 0, 24'h400000, 3'b000, 0, 0, 32'h3F800000, 4'b0000));
        vec.push_back(mk(0, 8'hFE, 1, 24'h800000, 3'b000, 0, 0, 32'h7F800000, 4'b0101));
        vec.push_back(mk(0, 8'hFE, 1, 24'h800000, 3'b000, 0, 1, 32'h7F7FFFFF, 4'b0101));
        vec.push_back(mk(1, 8'hFE, 1, 24'h800000, 3'b000, 0, 2, 32'hFF7FFFFF, 4'b0101));
        vec.push_back(mk(1, 8'hFE, 1, 24'h800000, 3'b000, 0, 3, 32'hFF800000, 4'b0101));
`ifdef FP_DENORM_EN
        vec.push_back(mk(0, 8'h01, 0, 24'h400000, 3'b010, 0, 0, 32'h00400000, 4'b0011));
        vec.push_back(mk(0, 8'h10, 0, 24'h000001, 3'b000, 0, 0, 32'h00008000, 4'b0000));
`else
        vec.push_back(mk(0, 8'h01, 0, 24'h400000, 3'b010, 0, 0, 32'h00000000, 4'b0011));
        vec.push_back(mk(0, 8'h10, 0, 24'h000001, 3'b000, 0, 0, 32'h00000000, 4'b0011));
`endif
        vec.push_back(mk(0, 8'h01, 0, 24'h7FFFFF, 3'b100, 0, 0, 32'h00800000, 4'b0011));
        vec.push_back(mk(0, 8'hFE, 0, 24'hFFFFFF, 3'b100, 0, 0, 32'h7F800000, 4'b0101));
        vec.push_back(mk(0, 8'h80, 0, 24'h400000, 3'b110, 0, 0, 32'h3F800002, 4'b0001));
        vec.push_back(mk(0, 8'h7F, 1, 24'h800001, 3'b000, 0, 0, 32'h40400000, 4'b0001));
        vec.push_back(mk(0, 8'h7F, 1, 24'h800001, 3'b000, 0, 2, 32'h40400001, 4'b0001));
        vec.push_back(mk(1, 8'h55, 0, 24'h123456, 3'b101, 3, 0, 32'h7FC00000, 4'b1000));
        vec.push_back(mk(1, 8'h00, 0, 24'h000000, 3'b000, 2, 0, 32'hFF800000, 4'b0000));
        vec.push_back(mk(1, 8'h00, 0, 24'h000000, 3'b000, 1, 0, 32'h80000000, 4'b0000));
        vec.push_back(mk(0, 8'h40, 0, 24'h000000, 3'b000, 0, 3, 32'h80000000, 4'b0000));
        vec.push_back(mk(1, 8'h40, 0, 24'h000000, 3'b000, 0, 0, 32'h80000000, 4'b0000));
        vec.push_back(mk(0, 8'h40, 0, 24'h000000, 3'b000, 0, 0, 32'h00000000, 4'b0000));

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(vec[0]);
        repeat (3) @(negedge clock);
        #4;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_result", 64'(out_result), 64'd0);
        chk("reset_flags", 64'(out_flags), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Latency through an empty pipe.
        send(vec[3]);
        #4;
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        #4;
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        @(negedge clock);

        foreach (vec[i]) send(vec[i]);
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) send(mk_rand());
        drain();
        rand_bp = 1'b0;
        @(negedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);

        // Stall: two beats fill the pipe, the third must wait.
        bpv[0] = vec[0]; bpv[1] = vec[1]; bpv[2] = vec[4];
        out_ready = 1'b0;
        acc = 0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            if (idx < 3) begin
                drive(bpv[idx]);
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            #4;
            if (in_ready && in_valid) begin
                sb_q.push_back({bpv[idx].res, bpv[idx].flags});
                idx++;
                acc++;
            end
            @(negedge clock);
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        #4;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_hold0", 64'(out_result), 64'(bpv[0].res));
        @(negedge clock);
        #4;
        chk("bp_hold1", 64'(out_result), 64'(bpv[0].res));
        chk("bp_hold_flags", 64'(out_flags), 64'(bpv[0].flags));
        @(negedge clock);
        out_ready = 1'b1;
        if (idx < 3) send(bpv[idx]);
        else in_valid = 1'b0;
        drain();

        // Reset with beats in flight.
        send(vec[1]);
        send(vec[5]);
        send(vec[6]);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clock);
        #4;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        #4;
        chk("postreset_idle", 64'(out_valid), 64'd0);
        @(negedge clock);
        send(vec[2]);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
